hist_deserializer: RTL and testbench
====================================

HIST_DESERIALIZER -- requirements
Module: hist_deserializer

Interface
REQ-001 Parameter WORD_W, default 24: bits per serial word.
REQ-002 Parameter FIFO_DEPTH, default 4: output FIFO depth in words (power of two, >=2).
REQ-003 Parameter CNT_W, default 16: width of word_count.
REQ-004 fast_clk_in  input  1  bit clock; all logic on its rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 serial_in  input  1  serial data bit, MSB of each word first.
REQ-007 bit_valid_in  input  1  high when serial_in carries a data bit this cycle.
REQ-008 clear_err  input  1  single-cycle pulse that clears the sticky error flags.
REQ-009 word_out  output  WORD_W  head-of-FIFO word.
REQ-010 word_valid  output  1  FIFO not empty; word_out valid.
REQ-011 word_ready  input  1  consumer accepts word_out when word_valid && word_ready.
REQ-012 word_count  output  CNT_W  number of words pushed into the FIFO, wraps modulo 2^CNT_W.
REQ-013 frame_err  output  1  sticky: partial word abandoned.
REQ-014 overflow  output  1  sticky: completed word dropped because FIFO full.
REQ-015 busy  output  1  high while state is SHIFT.

Function
REQ-016 FSM states: IDLE (bit_cnt=0, no partial word) and SHIFT (1..WORD_W-1 bits captured).
REQ-017 IDLE: bit_valid_in=1 -> capture serial_in as MSB, bit_cnt=1, go to SHIFT; otherwise stay.
REQ-018 SHIFT with bit_valid_in=1: shift serial_in in at LSB and increment bit_cnt.
REQ-019 Word completes on the edge that samples bit WORD_W: push {shift_reg[WORD_W-2:0], serial_in} into FIFO, bit_cnt=0, go to IDLE.
REQ-020 Back-to-back words: a valid bit in the cycle after completion starts the next word from IDLE with no gap cycle required.
REQ-021 SHIFT with bit_valid_in=0: discard partial word, set frame_err, go to IDLE.
REQ-022 Latency: word_valid rises on the same edge that completes the word when the FIFO was empty (word visible 1 cycle after the last bit is presented).
REQ-023 FIFO is first-word-fall-through; word_out is the oldest entry; pop occurs on an edge with word_valid && word_ready.
REQ-024 Push and pop in the same cycle are both honoured, including when the FIFO is full; occupancy is unchanged.
REQ-025 Push when full without a simultaneous pop: drop the new word, set overflow, do not increment word_count, leave FIFO contents intact.
REQ-026 word_ready while empty is ignored (no underflow, pointers unchanged).
REQ-027 word_count increments by 1 per accepted push and wraps from all-ones to 0.
REQ-028 clear_err clears frame_err and overflow; if a new error occurs in the same cycle, set wins.
REQ-029 word_out holds its value while word_valid=1 && word_ready=0.

Reset
REQ-030 Asserting reset immediately (asynchronously) forces state=IDLE, bit_cnt=0, shift_reg=0, FIFO empty, word_out=0, word_valid=0, word_count=0, frame_err=0, overflow=0, busy=0.
REQ-031 Reset mid-word or with the FIFO non-empty discards all partial and buffered data; no error flag is set by the reset itself.
REQ-032 After deassertion, the first bit_valid_in=1 sampled starts a new word.

Structure
REQ-033 WORD_W default, FSM state encoding and the FIFO_DEPTH default shall live in the shared histogram pipeline package, which the serializer stage also uses.
REQ-034 The FIFO shall be a separate sub-module, hist_word_fifo (parameterised width/depth, push/pop/full/empty), instantiated once.

Verification
REQ-035 One word 0xA5C3F0, MSB-first, 24 consecutive valid bits, word_ready=1 -> word_out=0xA5C3F0 with word_valid for exactly 1 cycle, starting 1 cycle after bit 24; word_count=1.
REQ-036 Three back-to-back words 0x000001, 0x800000, 0xFFFFFF (72 continuous valid bits) -> three words popped in order; no frame_err.
REQ-037 bit_valid_in drops after 10 bits, then a full word 0x123456 is sent -> frame_err=1, only 0x123456 is output; clear_err pulse -> frame_err=0.
REQ-038 word_ready=0 and 5 words sent with FIFO_DEPTH=4 -> overflow=1, word_count=4, words 1-4 are popped intact after word_ready=1.
REQ-039 FIFO full, with push and pop in the same cycle -> occupancy stays 4, order is preserved, overflow stays 0.
REQ-040 reset asserted after 12 bits of a word with 2 words buffered -> all outputs at reset values immediately; next full word 0xCAFE00 is received correctly.

Source files
------------

// File: rtl/hist_deserializer_pkg.sv
// Shared histogram pipeline definitions: word geometry, buffer sizing and the
// serial stage state encoding used by both the serializer and deserializer.
package hist_deserializer_pkg;

  localparam int unsigned HIST_WORD_W     = 24;
  localparam int unsigned HIST_FIFO_DEPTH = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } hist_state_e;

endpackage

// File: rtl/hist_word_fifo.sv
// First-word-fall-through word buffer; a push into a full FIFO is honoured
// only when a pop happens on the same edge.
module hist_word_fifo
  import hist_deserializer_pkg::*;
#(
  parameter int unsigned WIDTH = HIST_WORD_W,
  parameter int unsigned DEPTH = HIST_FIFO_DEPTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  // Empty reads as zero so the output needs no reset on the storage array.
  assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
  end

endmodule

// File: rtl/hist_deserializer.sv
// MSB-first serial-to-word deserializer feeding a FWFT output FIFO, with
// sticky framing/overflow flags and a pushed-word counter.
module hist_deserializer
  import hist_deserializer_pkg::*;
#(
  parameter int unsigned WORD_W     = HIST_WORD_W,
  parameter int unsigned FIFO_DEPTH = HIST_FIFO_DEPTH,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              fast_clk_in,
  input  logic              reset,
  input  logic              serial_in,
  input  logic              bit_valid_in,
  input  logic              clear_err,
  output logic [WORD_W-1:0] word_out,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [CNT_W-1:0]  word_count,
  output logic              frame_err,
  output logic              overflow,
  output logic              busy
);

  localparam int unsigned BW = $clog2(WORD_W);

  hist_state_e       state;
  hist_state_e       next_state;
  logic [WORD_W-1:0] shift_reg;
  logic [BW-1:0]     bit_cnt;
  logic [WORD_W-1:0] push_word;
  logic              word_done;
  logic              frame_set;
  logic              fifo_full;
  logic              fifo_empty;
  logic              pop;
  logic              push_ok;
  logic              overflow_set;

  assign word_done    = (state == ST_SHIFT) && bit_valid_in && (bit_cnt == BW'(WORD_W - 1));
  assign frame_set    = (state == ST_SHIFT) && !bit_valid_in;
  assign push_word    = {shift_reg[WORD_W-2:0], serial_in};
  assign word_valid   = !fifo_empty;
  assign pop          = word_valid && word_ready;
  assign push_ok      = word_done && (!fifo_full || pop);
  assign overflow_set = word_done && fifo_full && !pop;

  always_ff @(posedge fast_clk_in or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (bit_valid_in) next_state = ST_SHIFT;
      ST_SHIFT: if (!bit_valid_in || word_done) next_state = ST_IDLE;
      default:  next_state = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state == ST_SHIFT);
  end

  always_ff @(posedge fast_clk_in or posedge reset) begin
    if (reset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (state == ST_IDLE) begin
      if (bit_valid_in) begin
        shift_reg <= WORD_W'(serial_in);
        bit_cnt   <= BW'(1);
      end
    end else if (!bit_valid_in || word_done) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      shift_reg <= push_word;
      bit_cnt   <= bit_cnt + 1'b1;
    end
  end

  // Sticky flags: a new error in the clearing cycle wins over clear_err.
  always_ff @(posedge fast_clk_in or posedge reset) begin
    if (reset) begin
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
      word_count <= '0;
    end else begin
      frame_err <= frame_set || (frame_err && !clear_err);
      overflow  <= overflow_set || (overflow && !clear_err);
      if (push_ok) word_count <= word_count + CNT_W'(1);
    end
  end

  hist_word_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (fast_clk_in),
    .reset (reset),
    .push  (push_ok),
    .pop   (pop),
    .wdata (push_word),
    .rdata (word_out),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_hist_deserializer.sv
// Directed testbench for hist_deserializer with hand-computed expectations.
module tb_hist_deserializer;

  logic        fast_clk_in = 1'b0;
  logic        reset = 1'b1;
  logic        serial_in = 1'b0;
  logic        bit_valid_in = 1'b0;
  logic        clear_err = 1'b0;
  logic        word_ready = 1'b0;
  logic [23:0] word_out;
  logic        word_valid;
  logic [15:0] word_count;
  logic        frame_err;
  logic        overflow;
  logic        busy;

  int vectors = 0;
  int errors  = 0;

  hist_deserializer #(
    .WORD_W     (24),
    .FIFO_DEPTH (4),
    .CNT_W      (16)
  ) dut (
    .fast_clk_in  (fast_clk_in),
    .reset        (reset),
    .serial_in    (serial_in),
    .bit_valid_in (bit_valid_in),
    .clear_err    (clear_err),
    .word_out     (word_out),
    .word_valid   (word_valid),
    .word_ready   (word_ready),
    .word_count   (word_count),
    .frame_err    (frame_err),
    .overflow     (overflow),
    .busy         (busy)
  );

  always #5 fast_clk_in = ~fast_clk_in;

  // Present the top n bits of w MSB first; returns #1 after the last edge.
  task automatic send_bits(input logic [23:0] w, input int n, input logic rdy_last);
    for (int i = 0; i < n; i++) begin
      bit_valid_in = 1'b1;
      serial_in    = w[23-i];
      if (i == 23) word_ready = rdy_last;
      @(posedge fast_clk_in); #1;
    end
  endtask

  task automatic step();
    bit_valid_in = 1'b0;
    @(posedge fast_clk_in); #1;
  endtask

  task automatic test_reset();
    @(posedge fast_clk_in); #1;
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", word_valid); end
    vectors++; if (word_out !== 24'h0) begin errors++; $display("FAIL reset_word got %h want 000000", word_out); end
    vectors++; if (word_count !== 16'd0) begin errors++; $display("FAIL reset_count got %0d want 0", word_count); end
    vectors++; if ({frame_err, overflow, busy} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {frame_err, overflow, busy}); end
    reset = 1'b0;
    @(posedge fast_clk_in); #1;
  endtask

  task automatic test_single();
    word_ready = 1'b1;
    send_bits(24'hA5C3F0, 23, 1'b1);
    vectors++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy got %b want 1", busy); end
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL single_early got %b want 0", word_valid); end
    bit_valid_in = 1'b1; serial_in = 1'b0;
    @(posedge fast_clk_in); #1;
    vectors++; if (word_valid !== 1'b1) begin errors++; $display("FAIL single_valid got %b want 1", word_valid); end
    vectors++; if (word_out !== 24'hA5C3F0) begin errors++; $display("FAIL single_word got %h want a5c3f0", word_out); end
    vectors++; if (word_count !== 16'd1) begin errors++; $display("FAIL single_count got %0d want 1", word_count); end
    vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got %b want 0", busy); end
    step();
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL single_1cyc got %b want 0", word_valid); end
  endtask

  task automatic test_back_to_back();
    logic [23:0] w [3];
    w[0] = 24'h000001; w[1] = 24'h800000; w[2] = 24'hFFFFFF;
    word_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      send_bits(w[k], 24, 1'b1);
      vectors++; if (word_valid !== 1'b1 || word_out !== w[k]) begin errors++; $display("FAIL b2b_word%0d got %b/%h want 1/%h", k, word_valid, word_out, w[k]); end
    end
    step();
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %b want 0", word_valid); end
    vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL b2b_frame got %b want 0", frame_err); end
    vectors++; if (word_count !== 16'd4) begin errors++; $display("FAIL b2b_count got %0d want 4", word_count); end
  endtask

  task automatic test_frame_err();
    word_ready = 1'b1;
    send_bits(24'hFFC000, 10, 1'b1);
    step();
    vectors++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_set got %b want 1", frame_err); end
    vectors++; if (busy !== 1'b0 || word_valid !== 1'b0) begin errors++; $display("FAIL frame_discard got %b%b want 00", busy, word_valid); end
    send_bits(24'h123456, 24, 1'b1);
    vectors++; if (word_valid !== 1'b1 || word_out !== 24'h123456) begin errors++; $display("FAIL frame_next got %b/%h want 1/123456", word_valid, word_out); end
    vectors++; if (word_count !== 16'd5) begin errors++; $display("FAIL frame_count got %0d want 5", word_count); end
    step();
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL frame_only got %b want 0", word_valid); end
    send_bits(24'h000000, 3, 1'b1);
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    vectors++; if (frame_err !== 1'b1) begin errors++; $display("FAIL frame_setwins got %b want 1", frame_err); end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    vectors++; if (frame_err !== 1'b0) begin errors++; $display("FAIL frame_clear got %b want 0", frame_err); end
  endtask

  task automatic test_overflow();
    logic [23:0] w [5];
    w[0] = 24'h111111; w[1] = 24'h222222; w[2] = 24'h333333; w[3] = 24'h444444; w[4] = 24'h555555;
    word_ready = 1'b0;
    for (int k = 0; k < 5; k++) send_bits(w[k], 24, 1'b0);
    vectors++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set got %b want 1", overflow); end
    vectors++; if (word_count !== 16'd9) begin errors++; $display("FAIL ovf_count got %0d want 9", word_count); end
    vectors++; if (word_out !== 24'h111111) begin errors++; $display("FAIL ovf_hold got %h want 111111", word_out); end
    word_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      vectors++; if (word_valid !== 1'b1 || word_out !== w[k]) begin errors++; $display("FAIL ovf_pop%0d got %b/%h want 1/%h", k, word_valid, word_out, w[k]); end
      step();
    end
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got %b want 0", word_valid); end
    clear_err = 1'b1;
    step();
    clear_err = 1'b0;
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", overflow); end
  endtask

  task automatic test_full_push_pop();
    logic [23:0] w [5];
    w[0] = 24'hA00001; w[1] = 24'hB00002; w[2] = 24'hC00003; w[3] = 24'hD00004; w[4] = 24'hE00005;
    word_ready = 1'b0;
    for (int k = 0; k < 4; k++) send_bits(w[k], 24, 1'b0);
    send_bits(w[4], 24, 1'b1);
    word_ready = 1'b0;
    vectors++; if (overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf got %b want 0", overflow); end
    vectors++; if (word_count !== 16'd14) begin errors++; $display("FAIL fpp_count got %0d want 14", word_count); end
    word_ready = 1'b1;
    for (int k = 1; k < 5; k++) begin
      vectors++; if (word_valid !== 1'b1 || word_out !== w[k]) begin errors++; $display("FAIL fpp_pop%0d got %b/%h want 1/%h", k, word_valid, word_out, w[k]); end
      step();
    end
    vectors++; if (word_valid !== 1'b0) begin errors++; $display("FAIL fpp_occupancy got %b want 0", word_valid); end
  endtask

  task automatic test_reset_midword();
    word_ready = 1'b0;
    send_bits(24'h0F0F0F, 24, 1'b0);
    send_bits(24'hF0F0F0, 24, 1'b0);
    send_bits(24'hABCDEF, 12, 1'b0);
    #2 reset = 1'b1;
    #1;
    vectors++; if (word_valid !== 1'b0 || word_out !== 24'h0) begin errors++; $display("FAIL rst_fifo got %b/%h want 0/000000", word_valid, word_out); end
    vectors++; if (word_count !== 16'd0) begin errors++; $display("FAIL rst_count got %0d want 0", word_count); end
    vectors++; if ({frame_err, overflow, busy} !== 3'b000) begin errors++; $display("FAIL rst_flags got %b want 000", {frame_err, overflow, busy}); end
    bit_valid_in = 1'b0;
    @(posedge fast_clk_in); #1;
    reset = 1'b0;
    word_ready = 1'b1;
    send_bits(24'hCAFE00, 24, 1'b1);
    vectors++; if (word_valid !== 1'b1 || word_out !== 24'hCAFE00) begin errors++; $display("FAIL rst_next got %b/%h want 1/cafe00", word_valid, word_out); end
    vectors++; if (word_count !== 16'd1 || frame_err !== 1'b0) begin errors++; $display("FAIL rst_after got %0d/%b want 1/0", word_count, frame_err); end
    step();
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_frame_err();
    test_overflow();
    test_full_push_pop();
    test_reset_midword();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
